i2c_phase_timer: RTL and testbench

Parametrised successor to the I2C bit timer. Divides each I2C bit period into `PHASES` equal phases of `Ticks` clock cycles and emits a pulse at the end of every phase. It also reports the current phase index and flags the end of each full bit. The block supports periodic and one-shot operation and freezes on `Stop` to allow SCL clock stretching. It sits between the I2C master FSM, which consumes `Phase`/`BitDone` to drive SCL/SDA edges, and the register file, which supplies `Ticks`.

---
 rtl/i2c_timer_pkg.sv | 11 +
 rtl/i2c_tick_counter.sv | 28 ++
 rtl/i2c_phase_timer.sv | 90 +++++++++
 tb/tb_i2c_phase_timer.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/i2c_timer_pkg.sv
// rtl/i2c_timer_pkg.sv - shared FSM encodings and mode constants for the I2C phase timer
package i2c_timer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/i2c_tick_counter.sv
// rtl/i2c_tick_counter.sv - reload-on-expiry down-counter that times one phase
module i2c_tick_counter #(
   parameter int SIZE = 8
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            Load,
   input  logic            En,
   input  logic [SIZE-1:0] Value,
   output logic            Expire
);

   logic [SIZE-1:0] cnt;

   // Expiry is taken on the terminal count of 1 so a reload of T yields exactly T cycles.
   assign Expire = En && (cnt == SIZE'(1));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt <= '0;
      end else if (Load || Expire) begin
         cnt <= Value;
      end else if (En) begin
         cnt <= cnt - SIZE'(1);
      end
   end

endmodule

// File: rtl/i2c_phase_timer.sv
// rtl/i2c_phase_timer.sv - splits an I2C bit period into equal phases with stop/stretch hold
module i2c_phase_timer
   import i2c_timer_pkg::*;
#(
   parameter  int SIZE   = 8,
   parameter  int PHASES = 4,
   localparam int PW     = $clog2(PHASES)
) (
   input  logic            Clk,
   input  logic            Rst_n,
   input  logic            Start,
   input  logic            Stop,
   input  logic            Mode,
   input  logic [SIZE-1:0] Ticks,
   output logic            Out,
   output logic [PW-1:0]   Phase,
   output logic            BitDone,
   output logic            Busy
);

   logic [1:0]      state;
   logic [PW-1:0]   phase;
   logic [SIZE-1:0] ticks_q;
   logic            mode_q;
   logic            out_q;
   logic            bit_done_q;

   logic            load;
   logic            run_en;
   logic            expire;
   logic            wrap;
   logic [SIZE-1:0] value;

   // A zero tick count would never expire, so such a Start is ignored entirely.
   assign load   = Start && (Ticks != '0);
   assign run_en = !load && ((state == ST_RUN) || (state == ST_HOLD)) && !Stop;
   assign wrap   = expire && (phase == PW'(PHASES - 1));
   assign value  = load ? Ticks : ticks_q;

   i2c_tick_counter #(
      .SIZE (SIZE)
   ) u_tick_counter (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .Load   (load),
      .En     (run_en),
      .Value  (value),
      .Expire (expire)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= ST_IDLE;
         phase      <= '0;
         ticks_q    <= '0;
         mode_q     <= MODE_PERIODIC;
         out_q      <= 1'b0;
         bit_done_q <= 1'b0;
      end else begin
         out_q      <= expire;
         bit_done_q <= wrap;
         if (load) begin
            ticks_q <= Ticks;
            mode_q  <= Mode;
            phase   <= '0;
            state   <= ST_RUN;
         end else begin
            case (state)
               ST_IDLE: ;
               ST_RUN:  if (Stop) state <= ST_HOLD;
               ST_HOLD: if (!Stop) state <= ST_RUN;
               default: state <= ST_IDLE;
            endcase
            // The release edge out of HOLD may itself expire, so the one-shot exit overrides it.
            if (expire) begin
               phase <= wrap ? '0 : phase + PW'(1);
               if (wrap && (mode_q == MODE_ONESHOT)) begin
                  state <= ST_IDLE;
               end
            end
         end
      end
   end

   assign Out     = out_q;
   assign BitDone = bit_done_q;
   assign Phase   = phase;
   assign Busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_phase_timer.sv
// tb/tb_i2c_phase_timer.sv - table-driven scoreboard bench for i2c_phase_timer
module tb_i2c_phase_timer;

   localparam int SIZE   = 8;
   localparam int PHASES = 4;
   localparam int PW     = $clog2(PHASES);

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            stop;
   logic            mode;
   logic [SIZE-1:0] ticks;
   logic            out;
   logic [PW-1:0]   phase;
   logic            bit_done;
   logic            busy;

   i2c_phase_timer #(
      .SIZE   (SIZE),
      .PHASES (PHASES)
   ) dut (
      .Clk     (clk),
      .Rst_n   (rst_n),
      .Start   (start),
      .Stop    (stop),
      .Mode    (mode),
      .Ticks   (ticks),
      .Out     (out),
      .Phase   (phase),
      .BitDone (bit_done),
      .Busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   cyc;
      int   ph;
      logic bd;
   } ev_t;

   typedef struct {
      int   t;
      logic md;
      int   chg;
      int   s;
      int   len;
      int   run;
   } vec_t;

   ev_t  exp_q[$];
   vec_t vecs[9];
   int   n_checks;
   int   n_err;
   int   cyc;
   int   busy_cnt;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Advance one clock and observe the registered outputs at the following falling edge.
   task automatic tick();
      ev_t e;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (busy) busy_cnt++;
      if (bit_done && !out) check("bitdone_without_out", 1, 0);
      if (out) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_cycle", cyc, -1);
         end else begin
            e = exp_q.pop_front();
            check("out_cycle", cyc, e.cyc);
            check("out_phase", int'(phase), e.ph);
            check("out_bitdone", int'(bit_done), int'(e.bd));
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int k;
      int b0;
      int d;
      int tm;
      int nmax;
      int bexp;
      k    = cyc + 1;
      d    = (v.len > 0 && v.s <= v.t * PHASES) ? v.len : 0;
      nmax = v.md ? PHASES : 1000000;
      if (v.t != 0) begin
         for (int n = 1; n <= nmax; n++) begin
            tm = v.t * n + ((v.len > 0 && v.t * n >= v.s) ? v.len : 0);
            if (tm > v.run) break;
            exp_q.push_back('{k + tm, n % PHASES, (n % PHASES) == 0});
         end
      end
      if (v.t == 0)      bexp = 0;
      else if (!v.md)    bexp = v.run + 1;
      else               bexp = (v.run + 1 < v.t * PHASES + d) ? v.run + 1 : v.t * PHASES + d;
      start = 1'b1;
      ticks = SIZE'(v.t);
      mode  = v.md;
      b0    = busy_cnt;
      tick();
      check("phase_after_start", int'(phase), 0);
      check("busy_after_start", int'(busy), (v.t != 0) ? 1 : 0);
      start = 1'b0;
      ticks = SIZE'(v.chg);
      for (int e = 1; e <= v.run; e++) begin
         stop = (v.len > 0) && (e >= v.s) && (e < v.s + v.len);
         tick();
      end
      stop = 1'b0;
      check("busy_cycles", busy_cnt - b0, bexp);
      check("missing_out", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      n_checks = 0;
      n_err    = 0;
      cyc      = 0;
      busy_cnt = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      mode     = 1'b0;
      ticks    = '0;

      vecs[0] = '{5,   1'b0, 5,   0,  0, 45};
      vecs[1] = '{3,   1'b1, 3,   0,  0, 30};
      vecs[2] = '{0,   1'b0, 0,   0,  0, 50};
      vecs[3] = '{8,   1'b0, 8,   12, 3, 50};
      vecs[4] = '{1,   1'b0, 1,   0,  0, 12};
      vecs[5] = '{10,  1'b0, 10,  0,  0, 15};
      vecs[6] = '{6,   1'b0, 2,   0,  0, 30};
      vecs[7] = '{2,   1'b1, 2,   3,  2, 20};
      vecs[8] = '{255, 1'b1, 255, 0,  0, 1030};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out", int'(out), 0);
      check("reset_bitdone", int'(bit_done), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_phase", int'(phase), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Reset asserted mid-cycle while the period is held by Stop.
      run_vec('{2, 1'b0, 2, 0, 0, 4});
      stop = 1'b1;
      tick();
      tick();
      check("hold_busy", int'(busy), 1);
      check("hold_phase", int'(phase), 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_out", int'(out), 0);
      check("async_reset_bitdone", int'(bit_done), 0);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_phase", int'(phase), 0);
      tick();
      rst_n = 1'b1;
      stop  = 1'b0;
      run_vec('{4, 1'b0, 4, 0, 0, 9});

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
